// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared encodings and constants for the shift-add multiplier
package mult_pkg;

  localparam int         MULT_W    = 8;
  localparam logic [3:0] ITER_LAST = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/eightbitadd.sv
// rtl/eightbitadd.sv - 8-bit ripple-carry adder shared by the multiplier datapath
module eightbitadd (
  output logic [7:0] S,
  output logic       Cout,
  input  logic [7:0] A,
  input  logic [7:0] B
);

  logic [8:0] c;

  always_comb begin
    c = '0;
    S = '0;
    for (int i = 0; i < 8; i++) begin
      S[i]     = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = c[8];

endmodule

// File: rtl/shiftadd_mult8.sv
// rtl/shiftadd_mult8.sv - 8x8 unsigned sequential multiplier, one add per cycle
module shiftadd_mult8
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  if (WIDTH != MULT_W) begin : g_width_check
    $error("shiftadd_mult8: WIDTH must be 8, the shared adder is fixed width");
  end

  state_e     state_q, state_d;
  logic [7:0] m_q, m_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] add_b;
  logic [7:0] add_s;
  logic       add_cout;

  // B is muxed to zero rather than skipping the add, so every run is 8 cycles
  assign add_b = lo_q[0] ? m_q : 8'h00;

  eightbitadd u_add (
    .S    (add_s),
    .Cout (add_cout),
    .A    (hi_q),
    .B    (add_b)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          lo_d    = b;
          hi_d    = 8'h00;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // carry-out lands in hi[7], so the 16-bit product never overflows
        {hi_d, lo_d} = {add_cout, add_s, lo_q[7:1]};
        cnt_d        = cnt_q + 4'd1;
        if (cnt_q == ITER_LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= 8'h00;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {hi_q, lo_q};

endmodule

// File: tb/tb_shiftadd_mult8.sv
// tb/tb_shiftadd_mult8.sv - scoreboard bench for shiftadd_mult8
module tb_shiftadd_mult8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  typedef struct {
    logic [15:0] prod;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] last_prod;
  logic        have_last;

  shiftadd_mult8 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst_n) begin
      have_last = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", 32'(product), 32'(e.prod));
        chk("latency", 32'(cyc - e.acc), 32'd8);
        last_prod = e.prod;
        have_last = 1'b1;
      end
    end else if (!busy && have_last) begin
      chk("product_hold", 32'(product), 32'(last_prod));
    end
  end

  task automatic push_exp(input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    e.prod = 16'(int'(ea) * int'(eb));
    e.acc  = cyc;
    sb.push_back(e);
  endtask

  // Called at posedge+1 with the DUT idle; checks busy/done shape per cycle
  task automatic run_one(input logic [7:0] oa, input logic [7:0] ob);
    start = 1'b1;
    a     = oa;
    b     = ob;
    @(posedge clk);
    #1;
    push_exp(oa, ob);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("busy_shape", 32'(busy), 32'(k <= 9));
      chk("done_shape", 32'(done), 32'(k == 9));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_one(8'hD9, 8'h6D);
    run_one(8'hFF, 8'hFF);
    run_one(8'h00, 8'hA5);
    run_one(8'h01, 8'hC8);
    repeat (2) @(posedge clk);
    #1;

    // start pulsed at E3 with new operands must be ignored
    start = 1'b1;
    a     = 8'h37;
    b     = 8'h5A;
    @(posedge clk);
    #1;
    push_exp(8'h37, 8'h5A);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain();
    repeat (12) @(posedge clk);
    #1;

    // start held high: accepts at E0, E10, E20
    start = 1'b1;
    a     = 8'h9C;
    b     = 8'h3B;
    @(posedge clk);
    #1;
    push_exp(8'h9C, 8'h3B);
    a = 8'h12;
    b = 8'hF7;
    repeat (10) @(posedge clk);
    #1;
    push_exp(8'h12, 8'hF7);
    a = 8'hE5;
    b = 8'h81;
    repeat (10) @(posedge clk);
    #1;
    push_exp(8'hE5, 8'h81);
    start = 1'b0;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;

    // asynchronous reset at E4 aborts the run without a done
    start = 1'b1;
    a     = 8'hC3;
    b     = 8'h77;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_done_pending", 32'(sb.size()), 32'd0);
    run_one(8'd3, 8'd5);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      int         gap;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      gap = $urandom_range(0, 3);
      run_one(ra, rb);
      repeat (gap) @(posedge clk);
      #1;
    end

    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
